// File: rtl/input_port.sv
// Debounced 4-bit input port: two-flop synchronizer, per-word debounce counter,
// and a processor-facing read register with ready / sticky overrun flags.
module input_port #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] pin,
  input  logic       enabled,
  output logic [3:0] Q,
  output logic       ready,
  output logic       overrun
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    candidate;
  logic [3:0]    stable;
  logic [CW-1:0] cnt;
  logic          matched;
  logic          held;
  logic          accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  always_comb begin
    matched = (sync2 == candidate);
    held    = (cnt == CNT_MAX);
    accept  = matched && held && (candidate != stable);
  end

  // cnt saturates at CNT_MAX; a candidate equal to stable never re-accepts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      candidate <= '0;
      cnt       <= '0;
      stable    <= '0;
    end else begin
      if (!matched) begin
        candidate <= sync2;
        cnt       <= '0;
      end else if (!held) begin
        cnt <= cnt + 1'b1;
      end
      if (accept) stable <= candidate;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q       <= '0;
      ready   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (enabled) Q <= stable;
      if (accept) begin
        ready   <= 1'b1;
        overrun <= enabled ? 1'b0 : (overrun | ready);
      end else if (enabled) begin
        ready   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule
